// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
// Shared types and constants for the chip8 boot-and-run sequencer:
//   - run_state_e   : sequencer state encoding
//   - addr_t        : 12-bit core memory address
//   - FONT_BYTES    : size of the built-in hex font (16 glyphs x 5 rows)
//   - FONT_BASE_DEF / PROG_BASE_DEF : default load addresses
// -----------------------------------------------------------------------------
package chip8_pkg;

   typedef logic [11:0] addr_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RST_CORE  = 3'd1,
      ST_LOAD_FONT = 3'd2,
      ST_LOAD_PROG = 3'd3,
      ST_RUN       = 3'd4,
      ST_DONE      = 3'd5,
      ST_ERROR     = 3'd6
   } run_state_e;

   localparam int unsigned FONT_BYTES    = 80;
   localparam addr_t       FONT_BASE_DEF = 12'h050;
   localparam addr_t       PROG_BASE_DEF = 12'h200;

endpackage

// File: rtl/chip8_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// chip8_run_ctrl_if
// Bundles the host program-byte stream and the core memory write port.
//   prog_valid/prog_ready/prog_data/prog_last : host -> sequencer byte stream
//   mem_we/mem_addr/mem_wdata                 : sequencer -> core memory writes
// Modports:
//   master : host/board side (drives the byte stream, observes memory writes)
//   slave  : sequencer side (accepts bytes, drives memory writes)
// -----------------------------------------------------------------------------
interface chip8_run_ctrl_if;
   import chip8_pkg::*;

   logic        prog_valid;
   logic        prog_ready;
   logic [7:0]  prog_data;
   logic        prog_last;
   logic        mem_we;
   addr_t       mem_addr;
   logic [7:0]  mem_wdata;

   modport master (
      output prog_valid, prog_data, prog_last,
      input  prog_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  prog_valid, prog_data, prog_last,
      output prog_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/chip8_font_rom.sv
// -----------------------------------------------------------------------------
// chip8_font_rom
// Combinational 80x8 ROM holding the standard chip8 hex glyphs 0..F,
// five rows per glyph. Indices 80..127 read as zero.
//   idx  in  7  byte index
//   data out 8  glyph row
// -----------------------------------------------------------------------------
module chip8_font_rom
   import chip8_pkg::*;
(
   input  logic [6:0] idx,
   output logic [7:0] data
);

   // Byte 0 sits in the most significant bits.
   localparam logic [639:0] GLYPHS = {
      40'hF0_90_90_90_F0, 40'h20_60_20_20_70, 40'hF0_10_F0_80_F0, 40'hF0_10_F0_10_F0,
      40'h90_90_F0_10_10, 40'hF0_80_F0_10_F0, 40'hF0_80_F0_90_F0, 40'hF0_10_20_40_40,
      40'hF0_90_F0_90_F0, 40'hF0_90_F0_10_F0, 40'hF0_90_F0_90_90, 40'hE0_90_E0_90_E0,
      40'hF0_80_80_80_F0, 40'hE0_90_90_90_E0, 40'hF0_80_F0_80_F0, 40'hF0_80_F0_80_80
   };

   // Glyph row lookup.
   always_comb begin
      if (idx < 7'(FONT_BYTES)) begin
         data = GLYPHS[(10'd79 - {3'b000, idx}) * 10'd8 +: 8];
      end else begin
         data = 8'h00;
      end
   end

endmodule

// File: rtl/chip8_run_ctrl.sv
// -----------------------------------------------------------------------------
// chip8_run_ctrl
// Boot-and-run sequencer for the chip8 core: holds the core in reset, writes
// the font to FONT_BASE, streams the program image to PROG_BASE, then paces
// execution with single-cycle core_step pulses (free-run divider or one step
// per step_req) with an optional step limit.
// Ports:
//   clk, rst_n (synchronous, active low)
//   start, mode_step, step_req, halt_req, step_limit : host control
//   bus (chip8_run_ctrl_if.slave)                    : program stream + mem writes
//   core_rst, core_step, timer_tick                  : core control
//   busy, done, error, step_count                    : status
// Optional build macro CHIP8_RUN_TRACE_EN adds trace_valid / trace_step.
// All outputs are registered.
// -----------------------------------------------------------------------------
module chip8_run_ctrl
   import chip8_pkg::*;
#(
   parameter int unsigned TICK_DIV        = 50000,
   parameter int unsigned TIMER_RATIO     = 9,
   parameter int unsigned CORE_RST_CYCLES = 4,
   parameter int unsigned STEP_W          = 16,
   parameter addr_t       FONT_BASE       = FONT_BASE_DEF,
   parameter addr_t       PROG_BASE       = PROG_BASE_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode_step,
   input  logic              step_req,
   input  logic              halt_req,
   input  logic [STEP_W-1:0] step_limit,
   chip8_run_ctrl_if.slave   bus,
   output logic              core_rst,
   output logic              core_step,
   output logic              timer_tick,
   output logic              busy,
   output logic              done,
   output logic              error,
`ifdef CHIP8_RUN_TRACE_EN
   output logic              trace_valid,
   output logic [STEP_W-1:0] trace_step,
`endif
   output logic [STEP_W-1:0] step_count
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int RAT_W = (TIMER_RATIO > 1) ? $clog2(TIMER_RATIO) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
   localparam logic [RAT_W-1:0]  RAT_LAST = RAT_W'(TIMER_RATIO - 1);
   localparam logic [RAT_W-1:0]  RAT_ONE  = RAT_W'(1);
   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
   // Shared counter: reset-hold cycles, then font index (CORE_RST_CYCLES <= 256).
   localparam logic [7:0] RST_LAST = 8'(CORE_RST_CYCLES - 1);
   localparam logic [7:0] FONT_END = 8'(FONT_BYTES);

   run_state_e        state_r, state_s;
   logic [7:0]        cnt_r, cnt_s;
   addr_t             prog_addr_r, prog_addr_s;
   logic [DIV_W-1:0]  div_r, div_s;
   logic [RAT_W-1:0]  ratio_r, ratio_s;
   logic [STEP_W-1:0] step_count_r, step_count_s;
   logic              mode_q_r;
   logic              core_rst_r, core_step_r, timer_tick_r;
   logic              busy_r, done_r, error_r, prog_ready_r;
   logic              mem_we_r, mem_we_s;
   addr_t             mem_addr_r, mem_addr_s;
   logic [7:0]        mem_wdata_r, mem_wdata_s;
   logic              step_s, tick_s;
   logic              accept_s, mode_chg_s, limit_hit_s, step_due_s;
   logic [6:0]        rom_idx_s;
   logic [7:0]        font_byte_s;

   chip8_font_rom u_font_rom (
      .idx  (rom_idx_s),
      .data (font_byte_s)
   );

   assign accept_s    = bus.prog_valid && prog_ready_r;
   assign mode_chg_s  = mode_step ^ mode_q_r;
   // The step just issued reached the limit; stop before issuing another.
   assign limit_hit_s = core_step_r && (step_limit != {STEP_W{1'b0}}) &&
                        (step_count_r == step_limit);
   // core_step is registered, so a step decided here shows up next cycle.
   assign step_due_s  = mode_step ? step_req : (!mode_chg_s && (div_r == DIV_LAST));

   // Font ROM index: entry 0 is fetched during the last reset-hold cycle.
   always_comb begin
      if (state_r == ST_LOAD_FONT) begin
         rom_idx_s = cnt_r[6:0];
      end else begin
         rom_idx_s = 7'd0;
      end
   end

   // Next-state, counters and next registered outputs.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      prog_addr_s  = prog_addr_r;
      div_s        = div_r;
      ratio_s      = ratio_r;
      step_count_s = step_count_r;
      mem_we_s     = 1'b0;
      mem_addr_s   = mem_addr_r;
      mem_wdata_s  = mem_wdata_r;
      step_s       = 1'b0;
      tick_s       = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_s      = ST_RST_CORE;
               cnt_s        = 8'd0;
               prog_addr_s  = PROG_BASE;
               div_s        = {DIV_W{1'b0}};
               ratio_s      = {RAT_W{1'b0}};
               step_count_s = {STEP_W{1'b0}};
            end else begin
               state_s = state_r;
            end
         end
         ST_RST_CORE: begin
            if (cnt_r == RST_LAST) begin
               state_s     = ST_LOAD_FONT;
               cnt_s       = 8'd1;
               mem_we_s    = 1'b1;
               mem_addr_s  = FONT_BASE;
               mem_wdata_s = font_byte_s;
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         ST_LOAD_FONT: begin
            if (cnt_r == FONT_END) begin
               state_s = ST_LOAD_PROG;
            end else begin
               mem_we_s    = 1'b1;
               mem_addr_s  = FONT_BASE + {4'h0, cnt_r};
               mem_wdata_s = font_byte_s;
               cnt_s       = cnt_r + 8'd1;
            end
         end
         ST_LOAD_PROG: begin
            if (accept_s) begin
               mem_we_s    = 1'b1;
               mem_addr_s  = prog_addr_r;
               mem_wdata_s = bus.prog_data;
               prog_addr_s = prog_addr_r + 12'd1;
               if (bus.prog_last) begin
                  state_s = ST_RUN;
               end else if (prog_addr_r == 12'hFFF) begin
                  state_s = ST_ERROR;
               end else begin
                  state_s = ST_LOAD_PROG;
               end
            end else begin
               state_s = ST_LOAD_PROG;
            end
         end
         ST_RUN: begin
            if (mode_step || mode_chg_s || (div_r == DIV_LAST)) begin
               div_s = {DIV_W{1'b0}};
            end else begin
               div_s = div_r + DIV_ONE;
            end
            // Halt and limit take priority over a due step.
            if (halt_req || limit_hit_s) begin
               state_s = ST_DONE;
            end else if (step_due_s) begin
               step_s       = 1'b1;
               step_count_s = step_count_r + STEP_ONE;
               if (ratio_r == RAT_LAST) begin
                  tick_s  = 1'b1;
                  ratio_s = {RAT_W{1'b0}};
               end else begin
                  ratio_s = ratio_r + RAT_ONE;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs (outputs follow the next state).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 8'd0;
         prog_addr_r  <= PROG_BASE;
         div_r        <= {DIV_W{1'b0}};
         ratio_r      <= {RAT_W{1'b0}};
         step_count_r <= {STEP_W{1'b0}};
         mode_q_r     <= 1'b0;
         core_rst_r   <= 1'b1;
         core_step_r  <= 1'b0;
         timer_tick_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
         prog_ready_r <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= 12'h000;
         mem_wdata_r  <= 8'h00;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         prog_addr_r  <= prog_addr_s;
         div_r        <= div_s;
         ratio_r      <= ratio_s;
         step_count_r <= step_count_s;
         mode_q_r     <= mode_step;
         core_rst_r   <= !((state_s == ST_RUN) || (state_s == ST_DONE));
         core_step_r  <= step_s;
         timer_tick_r <= tick_s;
         busy_r       <= (state_s == ST_RST_CORE) || (state_s == ST_LOAD_FONT) ||
                         (state_s == ST_LOAD_PROG) || (state_s == ST_RUN);
         done_r       <= (state_s == ST_DONE);
         error_r      <= (state_s == ST_ERROR);
         prog_ready_r <= (state_s == ST_LOAD_PROG);
         mem_we_r     <= mem_we_s;
         mem_addr_r   <= mem_addr_s;
         mem_wdata_r  <= mem_wdata_s;
      end
   end

`ifdef CHIP8_RUN_TRACE_EN
   logic              trace_valid_r;
   logic [STEP_W-1:0] trace_step_r;

   // Trace of each issued step with its post-increment count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trace_valid_r <= 1'b0;
         trace_step_r  <= {STEP_W{1'b0}};
      end else begin
         trace_valid_r <= step_s;
         trace_step_r  <= step_count_s;
      end
   end

   assign trace_valid = trace_valid_r;
   assign trace_step  = trace_step_r;
`endif

   assign core_rst       = core_rst_r;
   assign core_step      = core_step_r;
   assign timer_tick     = timer_tick_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign error          = error_r;
   assign step_count     = step_count_r;
   assign bus.prog_ready = prog_ready_r;
   assign bus.mem_we     = mem_we_r;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_wdata  = mem_wdata_r;

endmodule
